multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle ARM control unit: main-FSM sequencer, ALU decoder and instruction decoder.
//  Produces the raw PCS/RegW/MemW/FlagW/NoWrite requests that the condition-check stage gates with CondEx.
//  Also produces all datapath steering signals per state.
//  Sits between the instruction register (Op/Funct/Rd) and the condition stage/datapath.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter (used only with CTRL_PERF_CNT_EN)
// PORTS
//  clk         in   1  clock; single clock domain
//  reset       in   1  asynchronous, active-high reset
//  Op          in   2  Instr[27:26]
//  Funct       in   6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
//  Rd          in   4  Instr[15:12]
//  PCS         out  1  PC-write request (branch or Rd==15 writeback), pre-condition
//  RegW        out  1  register-write request, pre-condition
//  MemW        out  1  memory-write request, pre-condition
//  FlagW       out  2  [1]=NZ write, [0]=CV write, pre-condition
//  NoWrite     out  1  suppress result write (CMP)
//  NextPC      out  1  unconditional PC write (FETCH)
//  IRWrite     out  1  load instruction register
//  AdrSrc      out  1  0=PC, 1=Result as memory address
//  ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA     out  1  0=RD1, 1=PC
//  ALUSrcB     out  2  00=RD2, 01=ExtImm, 10=const 4
//  ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
//  ImmSrc      out  2  equals Op
//  RegSrc      out  2  {Op==01, Op==10}
//  retired     out  CNT_W  instructions completed (CTRL_PERF_CNT_EN only)
// BEHAVIOUR
//  reset: state=FETCH asynchronously; outputs are FETCH values: IRWrite=1, NextPC=1, ALUSrcA=1,
//    ALUSrcB=10, ResultSrc=10, AdrSrc=0, ALUControl=00. All other outputs are 0.
//  Reset mid-instruction aborts it. No write request is issued after reset asserts.
//  Transitions, one per clk:
//    FETCH->DECODE.
//    DECODE: Op=01->MEMADR; Op=00 & Funct[5]=0->EXECR; Op=00 & Funct[5]=1->EXECI;
//      Op=10->BRANCH; Op=11->FETCH (undefined instruction; no writes).
//    MEMADR: Funct[0]=1->MEMRD, else ->MEMWR.
//    MEMRD->MEMWB->FETCH.  MEMWR->FETCH.  EXECR/EXECI->ALUWB->FETCH.  BRANCH->FETCH.
//  Cycles per instruction: LDR 5, STR 4, DP 4, B 3, undefined 2.
//  Per-state outputs (unlisted outputs=0):
//    DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
//    MEMADR: ALUSrcB=01.
//    MEMRD: ResultSrc=00, AdrSrc=1.
//    MEMWB: ResultSrc=01, RegW=1.
//    MEMWR: ResultSrc=00, AdrSrc=1, MemW=1.
//    EXECR: ALUSrcB=00, ALUOp on.
//    EXECI: ALUSrcB=01, ALUOp on.
//    ALUWB: ResultSrc=00, RegW=1.
//    BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
//  PCS = (RegW & Rd==4'hF) | Branch. This is combinational from state and Rd.
//  ALU decode applies only when ALUOp is on; otherwise ALUControl=00 (ADD), FlagW=00, NoWrite=0.
//    cmd 0100->00, 0010->01, 0000->10, 1100->11, 1010(CMP)->01 with NoWrite=1.
//    Any other cmd->00, FlagW=00.
//  FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl==00|01). CMP always has Funct[0]=1.
//  NoWrite is held through ALUWB for CMP, so the condition stage blocks RegWrite there.
//  All outputs are Moore-style from state plus registered-IR inputs; there is no input-to-output comb path
//    other than Rd/Op/Funct decode.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined: retired increments by 1 on each transition into FETCH from a
//    non-FETCH state (an undefined instruction counts). It wraps modulo 2^CNT_W and resets to 0.
//  CTRL_PERF_CNT_EN undefined: retired port and counter are absent.
// STRUCTURE
//  Shared package ctrl_pkg holds: state encodings (4-bit localparams FETCH..ALUWB),
//    ALUControl codes, ResultSrc/ALUSrcB codes, and Op codes.
//  Sub-module alu_decoder (combinational: Funct, ALUOp -> ALUControl, FlagW, NoWrite).
//  Top contains the state register, next-state logic, output decode, PCS, ImmSrc/RegSrc, and the counter.
// TESTING
//  ADD r1,r2,r3 (Op=00,Funct=001000,Rd=1): DECODE->EXECR->ALUWB, RegW=1 in ALUWB, PCS=0, ALUControl=00.
//  SUBS imm (Funct=100101): EXECI, ALUControl=01, FlagW=11.
//  CMP (Funct=010101): EXECR, NoWrite=1 and FlagW=11.
//  LDR (Op=01,Funct=011001): 5 states, MEMWB ResultSrc=01, RegW=1. STR (Funct=011000): MemW=1 only in MEMWR.
//  B (Op=10): BRANCH with PCS=1 and ALUSrcB=01. MOV-to-PC analogue, ADD Rd=15: PCS=1 in ALUWB.
//  Async reset asserted in MEMWR: state=FETCH immediately, MemW=0 same cycle.
//    Op=11: returns to FETCH after DECODE with no writes.
//  Perf (CTRL_PERF_CNT_EN): ADD, LDR, B sequence gives retired=3 after 12 clks.
//    Forcing the counter to 2^CNT_W-1 then retiring one instruction wraps it to 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// ============================================================================
// Module : ctrl_pkg
// Brief  : Shared encodings for the multi-cycle ARM control unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    BRANCH = 4'd8,
    ALUWB  = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  function automatic logic is_cmp(input logic [5:0] funct);
    return funct[4:1] == CMD_CMP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// ============================================================================
// Module : alu_decoder
// Brief  : Maps the data-processing cmd field to ALU control, flag writes and
//          the CMP result-suppress request.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  input  logic       i_aluop,
  output logic [1:0] o_alu_control,
  output logic [1:0] o_flag_w,
  output logic       o_no_write
);

  logic w_known;

  always_comb begin
    o_alu_control = ALU_ADD;
    o_flag_w      = 2'b00;
    o_no_write    = 1'b0;
    w_known       = 1'b0;
    if (i_aluop) begin
      case (i_funct[4:1])
        CMD_ADD: begin o_alu_control = ALU_ADD; w_known = 1'b1; end
        CMD_SUB: begin o_alu_control = ALU_SUB; w_known = 1'b1; end
        CMD_AND: begin o_alu_control = ALU_AND; w_known = 1'b1; end
        CMD_ORR: begin o_alu_control = ALU_ORR; w_known = 1'b1; end
        CMD_CMP: begin o_alu_control = ALU_SUB; o_no_write = 1'b1; w_known = 1'b1; end
        default: ;
      endcase
      // Carry/overflow only mean something for the arithmetic operations.
      if (w_known) begin
        o_flag_w[1] = i_funct[0];
        o_flag_w[0] = i_funct[0] & ((o_alu_control == ALU_ADD) | (o_alu_control == ALU_SUB));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
// ============================================================================
// Module : multicycle_ctrl_fsm
// Brief  : Multi-cycle ARM control unit (main FSM, ALU and instruction decode).
//          Define CTRL_PERF_CNT_EN to add the retired-instruction counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  output logic             PCS,
  output logic             RegW,
  output logic             MemW,
  output logic [1:0]       FlagW,
  output logic             NoWrite,
  output logic             NextPC,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  state_t r_state;
  state_t w_next;
  logic   w_branch;
  logic   w_aluop;
  logic   w_dec_no_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_branch  = 1'b0;
    w_aluop   = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    NextPC    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    case (r_state)
      FETCH: begin
        IRWrite = 1'b1; NextPC = 1'b1; ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
        w_next  = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
        case (Op)
          OP_MEM:  w_next = MEMADR;
          OP_DP:   w_next = Funct[5] ? EXECI : EXECR;
          OP_BR:   w_next = BRANCH;
          default: w_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = SRCB_EXTIMM;
        w_next  = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin AdrSrc = 1'b1; w_next = MEMWB; end
      MEMWB: begin ResultSrc = RES_DATA; RegW = 1'b1; w_next = FETCH; end
      MEMWR: begin AdrSrc = 1'b1; MemW = 1'b1; w_next = FETCH; end
      EXECR: begin ALUSrcB = SRCB_RD2; w_aluop = 1'b1; w_next = ALUWB; end
      EXECI: begin ALUSrcB = SRCB_EXTIMM; w_aluop = 1'b1; w_next = ALUWB; end
      ALUWB: begin RegW = 1'b1; w_next = FETCH; end
      BRANCH: begin
        ALUSrcB = SRCB_EXTIMM; ResultSrc = RES_ALURESULT; w_branch = 1'b1;
        w_next  = FETCH;
      end
      default: w_next = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_funct       (Funct),
    .i_aluop       (w_aluop),
    .o_alu_control (ALUControl),
    .o_flag_w      (FlagW),
    .o_no_write    (w_dec_no_write)
  );

  // CMP keeps NoWrite up into writeback so the condition stage can block RegWrite there.
  assign NoWrite = w_dec_no_write | ((r_state == ALUWB) & is_cmp(Funct));
  assign PCS     = (RegW & (Rd == 4'hF)) | w_branch;
  assign ImmSrc  = Op;
  assign RegSrc  = {Op == OP_MEM, Op == OP_BR};

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_retired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_retired <= '0;
    else if ((r_state != FETCH) && (w_next == FETCH))
      r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign retired = r_retired;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
// ============================================================================
// Module : tb_multicycle_ctrl_fsm
// Brief  : Self-checking bench for multicycle_ctrl_fsm against a per-instruction
//          cycle model (directed plus random instructions).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl_fsm;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    Op;
  logic [5:0]    Funct;
  logic [3:0]    Rd;
  logic          PCS, RegW, MemW, NoWrite, NextPC, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]    FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [CW-1:0] retired;
  logic [19:0]   obs;

  int total = 0;
  int bad   = 0;
  int model_ret = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW), .NoWrite(NoWrite),
    .NextPC(NextPC), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc)
`ifdef CTRL_PERF_CNT_EN
    , .retired(retired)
`endif
  );

`ifndef CTRL_PERF_CNT_EN
  assign retired = '0;
`endif

  assign obs = {PCS, RegW, MemW, FlagW, NoWrite, NextPC, IRWrite, AdrSrc,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};

  // Cycle counts per instruction class: LDR 5, STR 4, DP 4, B 3, undefined 2.
  function automatic int ncyc(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b01:   return f[0] ? 5 : 4;
      2'b00:   return 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  // Expected output vector for cycle k of an instruction.
  function automatic logic [19:0] expv(input logic [1:0] op, input logic [5:0] f,
                                       input logic [3:0] rd, input int k);
    logic pcs, regw, memw, nw, npc, irw, adr, srca;
    logic [1:0] fw, res, srcb, ctl;
    logic known;
    pcs = 0; regw = 0; memw = 0; nw = 0; npc = 0; irw = 0; adr = 0; srca = 0;
    fw = 0; res = 0; srcb = 0; ctl = 0; known = 0;
    if (k == 0) begin
      irw = 1; npc = 1; srca = 1; srcb = 2'b10; res = 2'b10;
    end else if (k == 1) begin
      srca = 1; srcb = 2'b10; res = 2'b10;
    end else if (op == 2'b01) begin
      if (k == 2) srcb = 2'b01;
      else if (k == 3) begin adr = 1; memw = !f[0]; end
      else begin res = 2'b01; regw = 1; end
    end else if (op == 2'b00) begin
      if (k == 2) begin
        srcb = f[5] ? 2'b01 : 2'b00;
        case (f[4:1])
          4'b0100: begin ctl = 2'b00; known = 1; end
          4'b0010: begin ctl = 2'b01; known = 1; end
          4'b0000: begin ctl = 2'b10; known = 1; end
          4'b1100: begin ctl = 2'b11; known = 1; end
          4'b1010: begin ctl = 2'b01; known = 1; nw = 1; end
          default: ;
        endcase
        if (known) fw = {f[0], f[0] & (ctl < 2)};
      end else begin
        regw = 1; nw = (f[4:1] == 4'b1010);
      end
    end else if (op == 2'b10) begin
      srcb = 2'b01; res = 2'b10; pcs = 1;
    end
    pcs = pcs | (regw & (rd == 4'hF));
    return {pcs, regw, memw, fw, nw, npc, irw, adr, res, srca, srcb, ctl,
            op, (op == 2'b01), (op == 2'b10)};
  endfunction

  task automatic check(input string tag, input logic [19:0] o, input logic [19:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check_ret(input string tag);
`ifdef CTRL_PERF_CNT_EN
    logic [CW-1:0] e;
    e = model_ret[CW-1:0];
    total++;
    assert (retired === e) else begin
      bad++;
      $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, e);
    end
`endif
  endtask

  // Enter with state FETCH, just after a rising edge; leave the same way.
  task automatic run_instr(input string name, input logic [1:0] op,
                           input logic [5:0] f, input logic [3:0] rd);
    Op = op; Funct = f; Rd = rd;
    for (int k = 0; k < ncyc(op, f); k++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", name, k), obs, expv(op, f, rd, k));
      @(posedge clk); #1;
    end
    model_ret++;
    check_ret(name);
  endtask

  initial begin
    logic [1:0] rop;
    logic [5:0] rf;
    logic [3:0] rrd;

    reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'b0;
    @(negedge clk);
    check("reset", obs, expv(2'b00, 6'b0, 4'b0, 0));
    check_ret("reset retired");
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr("ADD", 2'b00, 6'b001000, 4'd1);
    run_instr("LDR", 2'b01, 6'b011001, 4'd3);
    run_instr("B",   2'b10, 6'b000000, 4'd0);
    check_ret("perf ADD-LDR-B");

    run_instr("SUBS imm", 2'b00, 6'b100101, 4'd2);
    run_instr("CMP",      2'b00, 6'b010101, 4'd0);
    run_instr("STR",      2'b01, 6'b011000, 4'd4);
    run_instr("ADD pc",   2'b00, 6'b001000, 4'hF);
    run_instr("LDR pc",   2'b01, 6'b011001, 4'hF);
    run_instr("ANDS",     2'b00, 6'b000001, 4'd5);
    run_instr("ORR imm",  2'b00, 6'b111000, 4'd6);
    run_instr("UNDEF",    2'b11, 6'b101010, 4'hF);
    run_instr("odd cmd",  2'b00, 6'b011111, 4'd7);

    // Reset asserted while a store is in MEMWR.
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("STR-abort c%0d", k), obs, expv(Op, Funct, Rd, k));
      if (k < 3) begin @(posedge clk); #1; end
    end
    #2 reset = 1'b1;
    #1 check("async reset in MEMWR", obs, expv(2'b01, 6'b011000, 4'd2, 0));
    check("MemW after reset", {19'b0, MemW}, 20'b0);
    model_ret = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_ret("retired after reset");

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      rf  = 6'($urandom_range(0, 63));
      rrd = 4'($urandom_range(0, 15));
      run_instr($sformatf("rnd%0d", i), rop, rf, rrd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
